// File: rtl/alu_server.sv
// alu_server: valid/ready 32-bit ALU server, iterative 1-bit/cycle shifter unless ALU_SERVER_BARREL_SHIFT_EN selects single-cycle shifts
module alu_server (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  state_t state, state_n;
  logic [31:0] acc, acc_n, res, sra_res;
  logic err, err_n;
`ifndef ALU_SERVER_BARREL_SHIFT_EN
  logic [4:0] cnt, cnt_n;
  logic sra, sra_n;
`endif
  assign sra_res = $signed(req_a) >>> req_b[4:0];
  assign res = req_op == 3'd0 ? req_a + req_b :
               req_op == 3'd1 ? req_a - req_b :
               req_op == 3'd2 ? req_a & req_b :
               req_op == 3'd3 ? req_a | req_b :
               req_op == 3'd4 ? req_a >> req_b[4:0] :
               req_op == 3'd5 ? sra_res : 32'd0;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_data  = acc;
  assign rsp_err   = err;
  always_comb begin
    state_n = state;
    acc_n   = acc;
    err_n   = err;
`ifndef ALU_SERVER_BARREL_SHIFT_EN
    cnt_n   = cnt;
    sra_n   = sra;
`endif
    case (state)
      IDLE: if (req_valid) begin
        state_n = RESP;
        err_n   = req_op[2:1] == 2'b11;
        acc_n   = res;
`ifndef ALU_SERVER_BARREL_SHIFT_EN
        sra_n   = req_op[0];
        if (req_op[2:1] == 2'b10) begin
          acc_n   = req_a;
          cnt_n   = req_b[4:0];
          state_n = req_b[4:0] == 5'd0 ? RESP : SHIFT;
        end
`endif
      end
`ifndef ALU_SERVER_BARREL_SHIFT_EN
      SHIFT: begin
        acc_n   = {sra & acc[31], acc[31:1]};
        cnt_n   = cnt - 5'd1;
        state_n = cnt == 5'd1 ? RESP : SHIFT;
      end
`endif
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      err   <= 1'b0;
`ifndef ALU_SERVER_BARREL_SHIFT_EN
      cnt   <= '0;
      sra   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      acc   <= acc_n;
      err   <= err_n;
`ifndef ALU_SERVER_BARREL_SHIFT_EN
      cnt   <= cnt_n;
      sra   <= sra_n;
`endif
    end
  end
endmodule

// File: doc/alu_server.md
ALU_SERVER -- requirements
Module: alu_server

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 The block SHALL have port req_valid, input, 1 bit: the requester presents an operation.
REQ-004 The block SHALL have port req_ready, output, 1 bit: the block can accept an operation.
REQ-005 The block SHALL have port req_a, input, 32 bits: operand A.
REQ-006 The block SHALL have port req_b, input, 32 bits: operand B.
REQ-007 The block SHALL have port req_op, input, 3 bits: operation code.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a result is held on rsp_data.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port rsp_data, output, 32 bits: the result.
REQ-011 The block SHALL have port rsp_err, output, 1 bit: the op code was unsupported.

Function
REQ-012 Op codes SHALL be: 000 add; 001 sub (A-B); 010 and; 011 or; 100 srl (A >> B[4:0], logical); 101 sra (A >>> B[4:0], arithmetic). 110 and 111 are unsupported.
REQ-013 Add and sub SHALL be modulo 2^32, with no carry or overflow output.
REQ-014 Shift amount SHALL be req_b[4:0] only; req_b[31:5] SHALL be ignored.
REQ-015 The FSM SHALL have states IDLE, SHIFT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-017 Accept of add/sub/and/or SHALL register the result and move to RESP; rsp_valid rises 1 cycle after accept.
REQ-018 Accept of an unsupported op SHALL set rsp_data to 0 and rsp_err to 1, then move to RESP; latency is 1 cycle.
REQ-019 Accept of srl/sra SHALL load accumulator=A and count=B[4:0].
  - If count is 0, the FSM SHALL go directly to RESP with rsp_data=A.
  - Otherwise it SHALL go to SHIFT.
REQ-020 Each SHIFT cycle SHALL shift the accumulator by 1 bit (zero fill for srl, sign fill for sra) and decrement count.
  - When count reaches 0, the FSM SHALL go to RESP.
  - rsp_valid therefore rises n+1 cycles after accept, for shift amount n.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_err SHALL be held stable until rsp_ready is sampled 1.
  - On that cycle the FSM SHALL return to IDLE.
  - rsp_err SHALL be 0 for all supported ops.
REQ-022 req_* inputs SHALL be ignored outside IDLE; operands are captured only at accept.
REQ-023 Maximum throughput SHALL be one operation per 2 cycles, since a RESP-to-IDLE transition is needed before the next accept.

Reset
REQ-024 When reset is 1 at a clock edge, the block SHALL go to IDLE and clear accumulator, count, rsp_data and rsp_err to 0; rsp_valid SHALL be 0 and req_ready SHALL be 1.
REQ-025 Reset SHALL take priority over every transition, including mid-SHIFT and RESP with rsp_ready=1; the in-flight operation SHALL be discarded with no response.

Configuration
REQ-026 With macro ALU_SERVER_BARREL_SHIFT_EN defined, srl/sra SHALL complete like add (1-cycle latency, SHIFT never entered), and the counter register SHALL be omitted.
REQ-027 Without ALU_SERVER_BARREL_SHIFT_EN, shifts SHALL be iterative as in REQ-019 and REQ-020.
  - The bench SHALL check result values in both builds, and latency according to the build.

Verification
REQ-028 A=0x8000_00F1, B=4, op=000, rsp_ready=1 -> rsp_data=0x8000_00F5, rsp_err=0, rsp_valid 1 cycle after accept.
REQ-029 Same A and B, op=001 -> rsp_data 0x8000_00ED; op=010 -> 0x0000_0000; op=011 -> 0x8000_00F5.
REQ-030 Same A and B, op=100 -> rsp_data 0x0800_000F; op=101 -> 0xF800_000F; rsp_valid 5 cycles after accept (1 cycle with the macro); req_ready=0 throughout.
REQ-031 op=111 -> rsp_data 0, rsp_err 1; then rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_data stable, req_ready=0, and a new req_valid is not accepted.
REQ-032 op=101, A=0x8000_0000, B=31, reset asserted 10 cycles after accept -> next cycle req_ready=1, rsp_valid=0, rsp_data=0, and no response is ever produced.
REQ-033 op=100, B=0x0000_0020 (shift amount 0) -> rsp_data=A, rsp_valid 1 cycle after accept.
